// File: rtl/pwm_pkg.sv
// Shared types, default constants and the duty-code helper for the PWM measurement block.
package pwm_pkg;

    typedef enum logic [1:0] {
        SYNC,
        HIGH,
        LOW,
        STUCK
    } state_t;

    localparam int NOM_PERIOD_DEF = 256;
    localparam int TIMEOUT_DEF    = 1024;

    // Generator encoding: d+1 high cycles is code d; 0 or more than 256 cycles saturates.
    function automatic logic [7:0] sat8(input logic [31:0] hi);
        if (hi == 32'd0 || hi > 32'd256) begin
            return 8'hFF;
        end
        return 8'(hi - 32'd1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchronizer for an asynchronous level with single-cycle rise/fall strobes.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            // NOTE: non-blocking so each flop takes the previous stage's old value, forming a real shift chain.
            r_s1 <= async_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign lvl  = r_s2;
    assign rise = r_s2 & ~r_s3;
    assign fall = ~r_s2 & r_s3;

endmodule

// File: rtl/pwm_meas.sv
// PWM receiver: measures high time and period between synchronized rising edges,
// reports the generator's 8-bit duty code and flags a line stuck high or low.
module pwm_meas
    import pwm_pkg::*;
#(
    parameter int CW         = 16,
    parameter int NOM_PERIOD = NOM_PERIOD_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          PWM_in,
    output logic [CW-1:0] hi_time,
    output logic [CW-1:0] period,
    output logic [7:0]    duty,
    output logic          vld,
    output logic          per_err,
    output logic          stuck_hi,
    output logic          stuck_lo
);

    localparam logic [CW-1:0] L_CNT_MAX = '1;
    localparam logic [CW-1:0] L_TIMEOUT = CW'(TIMEOUT);
    localparam logic [CW-1:0] L_NOM     = CW'(NOM_PERIOD);

    logic          w_lvl;
    logic          w_rise;
    logic          w_fall;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_hi_lat;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_tmo_hit;
    logic          w_report;
    logic          w_timeout;

    logic [CW-1:0] r_hi_time;
    logic [CW-1:0] r_period;
    logic [7:0]    r_duty;
    logic          r_vld;
    logic          r_per_err;
    logic          r_stuck_hi;
    logic          r_stuck_lo;

    sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (PWM_in),
        .lvl      (w_lvl),
        .rise     (w_rise),
        .fall     (w_fall)
    );

    // cnt restarts at 1 on rise, so it reads H at the fall and P at the next rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hi_lat <= '0;
        end else begin
            if (w_rise) begin
                r_cnt <= CW'(1);
            end else if (r_cnt != L_CNT_MAX) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_fall) begin
                r_hi_lat <= r_cnt;
            end
        end
    end

    assign w_tmo_hit = (r_cnt == L_TIMEOUT) && !w_rise && !w_fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
        w_state_nxt = r_state;
        w_report    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            SYNC: begin
                if (w_rise) begin
                    w_state_nxt = HIGH;
                end else if (w_tmo_hit) begin
                    w_state_nxt = STUCK;
                    w_timeout   = 1'b1;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_state_nxt = LOW;
                end else if (w_tmo_hit) begin
                    w_state_nxt = STUCK;
                    w_timeout   = 1'b1;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_state_nxt = HIGH;
                    w_report    = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_nxt = STUCK;
                    w_timeout   = 1'b1;
                end
            end
            STUCK: begin
                if (w_rise) begin
                    w_state_nxt = HIGH;
                end
            end
            default: begin
                w_state_nxt = SYNC;
            end
        endcase
    end

    // A timeout keeps the last measurement; only the matching flag changes, and a dead-low line forces duty to full scale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi_time  <= '0;
            r_period   <= '0;
            r_duty     <= '0;
            r_vld      <= 1'b0;
            r_per_err  <= 1'b0;
            r_stuck_hi <= 1'b0;
            r_stuck_lo <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            if (w_report) begin
                r_period   <= r_cnt;
                r_hi_time  <= r_hi_lat;
                r_duty     <= sat8(32'(r_hi_lat));
                r_per_err  <= (r_cnt != L_NOM);
                r_stuck_hi <= 1'b0;
                r_stuck_lo <= 1'b0;
                r_vld      <= 1'b1;
            end else if (w_timeout) begin
                r_vld <= 1'b1;
                if (w_lvl) begin
                    r_stuck_hi <= 1'b1;
                end else begin
                    r_stuck_lo <= 1'b1;
                    r_duty     <= 8'hFF;
                end
            end
        end
    end

    assign hi_time  = r_hi_time;
    assign period   = r_period;
    assign duty     = r_duty;
    assign vld      = r_vld;
    assign per_err  = r_per_err;
    assign stuck_hi = r_stuck_hi;
    assign stuck_lo = r_stuck_lo;

endmodule

// File: tb/tb_pwm_meas.sv
// Bench for pwm_meas: timestamp-based reference model checked every cycle, plus fixed
// generator scenarios with hand-computed expectations and a randomized tail.
module tb_pwm_meas;

    localparam int TIMEOUT = 1024;
    localparam int NOM     = 256;
    localparam int CNT_MAX = 65535;

    logic        clk;
    logic        rst_n;
    logic        pwm_in;
    logic [15:0] hi_time;
    logic [15:0] period;
    logic [7:0]  duty;
    logic        vld;
    logic        per_err;
    logic        stuck_hi;
    logic        stuck_lo;

    int total = 0;
    int bad   = 0;

    pwm_meas #(.CW(16), .NOM_PERIOD(NOM), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .PWM_in   (pwm_in),
        .hi_time  (hi_time),
        .period   (period),
        .duty     (duty),
        .vld      (vld),
        .per_err  (per_err),
        .stuck_hi (stuck_hi),
        .stuck_lo (stuck_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int code_of(input int h);
        return (h >= 1 && h <= 256) ? h - 1 : 255;
    endfunction

    // Reference state: input delay line, last rise (or reset) timestamp and report eligibility.
    int cyc = 0;
    int anchor = 0;
    int m_hi_lat = 0;
    bit m_s1 = 0, m_lvl = 0, m_lvl_d = 0;
    bit armed = 0, fell = 0, stuck = 0, m_ok = 0;
    int e_hi = 0, e_per = 0, e_duty = 0;
    bit e_vld = 0, e_perr = 0, e_shi = 0, e_slo = 0;
    int n_vld = 0;
    int last_vld_cyc = -1;
    int vld_gap = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_s1 = 0; m_lvl = 0; m_lvl_d = 0;
                anchor = cyc; m_hi_lat = 0;
                armed = 0; fell = 0; stuck = 0;
                e_hi = 0; e_per = 0; e_duty = 0;
                e_vld = 0; e_perr = 0; e_shi = 0; e_slo = 0;
                m_ok = 1;
            end else if (m_ok) begin
                bit rise, fall;
                int cnt;
                rise = m_lvl && !m_lvl_d;
                fall = !m_lvl && m_lvl_d;
                cnt = cyc - 1 - anchor;
                if (cnt > CNT_MAX) cnt = CNT_MAX;
                e_vld = 0;
                if (rise) begin
                    if (armed && fell) begin
                        e_per  = cnt;
                        e_hi   = m_hi_lat;
                        e_duty = code_of(m_hi_lat);
                        e_perr = (cnt != NOM);
                        e_shi  = 0;
                        e_slo  = 0;
                        e_vld  = 1;
                    end
                    armed = 1; fell = 0; stuck = 0;
                    anchor = cyc - 1;
                end else if (fall) begin
                    m_hi_lat = cnt;
                    if (armed) fell = 1;
                end else if (!stuck && cnt == TIMEOUT) begin
                    e_vld = 1;
                    if (m_lvl) begin
                        e_shi = 1;
                    end else begin
                        e_slo  = 1;
                        e_duty = 255;
                    end
                    stuck = 1; armed = 0; fell = 0;
                end
                m_lvl_d = m_lvl;
                m_lvl   = m_s1;
                m_s1    = pwm_in;
            end

            @(negedge clk);
            if (m_ok) begin
                check("vld", 32'(vld), 32'(e_vld));
                check("hi_time", 32'(hi_time), 32'(e_hi));
                check("period", 32'(period), 32'(e_per));
                check("duty", 32'(duty), 32'(e_duty));
                check("per_err", 32'(per_err), 32'(e_perr));
                check("stuck_hi", 32'(stuck_hi), 32'(e_shi));
                check("stuck_lo", 32'(stuck_lo), 32'(e_slo));
            end
            if (vld === 1'b1) begin
                n_vld++;
                if (last_vld_cyc >= 0) vld_gap = cyc - last_vld_cyc;
                last_vld_cyc = cyc;
            end
        end
    end

    task automatic drive(input logic level, input int n);
        pwm_in = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic gen(input int d, input int n);
        repeat (n) begin
            if (d >= 255) begin
                drive(1'b0, 256);
            end else begin
                drive(1'b1, d + 1);
                drive(1'b0, 255 - d);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int sweep [4] = '{0, 1, 127, 254};
        pwm_in = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Duty 8'h40: first report three edges after the second input rise.
        drive(1'b0, 10);
        gen(8'h40, 1);
        pwm_in = 1'b1;
        @(negedge clk); #1;
        check("d40_no_vld_before_report", 32'(n_vld), 32'd0);
        check("d40_vld_k1", 32'(vld), 32'd0);
        @(negedge clk); #1;
        check("d40_vld_k2", 32'(vld), 32'd0);
        @(negedge clk); #1;
        check("d40_vld_k3", 32'(vld), 32'd1);
        check("d40_hi_time", 32'(hi_time), 32'd65);
        check("d40_period", 32'(period), 32'd256);
        check("d40_duty", 32'(duty), 32'h40);
        check("d40_per_err", 32'(per_err), 32'd0);
        drive(1'b1, 62);
        drive(1'b0, 191);
        gen(8'h40, 2);
        #1;
        check("d40_vld_gap", 32'(vld_gap), 32'd256);

        // Duty sweep round-trips exactly.
        foreach (sweep[i]) begin
            gen(sweep[i], 3);
            #1;
            check("sweep_duty", 32'(duty), 32'(sweep[i]));
            check("sweep_hi_time", 32'(hi_time), 32'(sweep[i] + 1));
            check("sweep_stuck_hi", 32'(stuck_hi), 32'd0);
            check("sweep_stuck_lo", 32'(stuck_lo), 32'd0);
        end

        // Dead-low line: one timeout report, nothing more while it stays low.
        base = n_vld;
        drive(1'b0, 1500);
        #1;
        check("lo_vld_count", 32'(n_vld - base), 32'd1);
        check("lo_stuck_lo", 32'(stuck_lo), 32'd1);
        check("lo_duty", 32'(duty), 32'hFF);
        check("lo_hi_time_held", 32'(hi_time), 32'd255);
        check("lo_period_held", 32'(period), 32'd256);

        gen(8'h20, 3);
        #1;
        check("recover_duty", 32'(duty), 32'h20);
        check("recover_stuck_lo", 32'(stuck_lo), 32'd0);

        // Stuck-high line: duty keeps its last value; recovery needs two rises.
        drive(1'b1, 10);
        #1;
        base = n_vld;
        drive(1'b1, 1990);
        #1;
        check("hi_vld_count", 32'(n_vld - base), 32'd1);
        check("hi_stuck_hi", 32'(stuck_hi), 32'd1);
        check("hi_duty_held", 32'(duty), 32'h20);
        base = n_vld;
        gen(8'h10, 2);
        #1;
        check("hi_first_rise_silent", 32'(n_vld - base), 32'd0);
        gen(8'h10, 1);
        #1;
        check("hi_recover_count", 32'(n_vld - base), 32'd1);
        check("hi_recover_duty", 32'(duty), 32'h10);
        check("hi_recover_flag", 32'(stuck_hi), 32'd0);

        // Hand pulse: 300 high, 100 low.
        drive(1'b1, 300);
        drive(1'b0, 100);
        drive(1'b1, 3);
        #1;
        check("hand_vld", 32'(vld), 32'd1);
        check("hand_period", 32'(period), 32'd400);
        check("hand_hi_time", 32'(hi_time), 32'd300);
        check("hand_duty", 32'(duty), 32'hFF);
        check("hand_per_err", 32'(per_err), 32'd1);
        drive(1'b1, 50);
        drive(1'b0, 100);

        // One-cycle reset in the middle of a high phase.
        gen(8'h80, 2);
        drive(1'b1, 60);
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("rst_hi_time", 32'(hi_time), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_duty", 32'(duty), 32'd0);
        check("rst_vld", 32'(vld), 32'd0);
        check("rst_per_err", 32'(per_err), 32'd0);
        check("rst_stuck_hi", 32'(stuck_hi), 32'd0);
        check("rst_stuck_lo", 32'(stuck_lo), 32'd0);
        rst_n = 1'b1;
        base = n_vld;
        drive(1'b1, 68);
        drive(1'b0, 127);
        #1;
        check("rst_one_rise_silent", 32'(n_vld - base), 32'd0);
        gen(8'h80, 1);
        #1;
        check("rst_second_rise_reports", 32'(n_vld - base), 32'd1);
        gen(8'h80, 1);
        #1;
        check("rst_after_duty", 32'(duty), 32'h80);
        check("rst_after_hi_time", 32'(hi_time), 32'd129);
        check("rst_after_period", 32'(period), 32'd256);
        check("rst_after_per_err", 32'(per_err), 32'd0);

        // Randomized tail, checked cycle by cycle against the model.
        for (int it = 0; it < 25; it++) begin
            int mode;
            mode = int'($urandom_range(0, 9));
            if (mode <= 4) begin
                gen(int'($urandom_range(0, 254)), 1);
            end else if (mode <= 7) begin
                drive(1'b1, int'($urandom_range(1, 400)));
                drive(1'b0, int'($urandom_range(1, 400)));
            end else if (mode == 8) begin
                repeat (6) begin
                    drive(1'b1, int'($urandom_range(1, 3)));
                    drive(1'b0, int'($urandom_range(1, 3)));
                end
            end else begin
                drive(1'b1, int'($urandom_range(1, 50)));
                drive(1'b0, 1100);
            end
            if ($urandom_range(0, 15) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        gen(8'h55, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
